uart_rx_deser: RTL and testbench
================================

// Module: uart_rx_deser
// PURPOSE
//   Serial receive front end for the UART peripheral. Oversamples the async rx line and
//   deserializes 8N1-style frames (1 start, DATA_BITS data LSB-first, 1 stop).
//   Delivers each byte through a valid/ready handshake to the UART register block.
//   Flags framing errors and overruns for the rx IRQ logic.
// PARAMETERS
//   CLK_DIV    4   i_clk cycles per oversample tick (>=1); baud = f_clk/(CLK_DIV*OVERSAMPLE)
//   OVERSAMPLE 16  ticks per bit (even, >=4)
//   DATA_BITS  8   data bits per frame (5..8)
// PORTS
//   i_clk        in   1          system clock, all logic on rising edge
//   i_reset      in   1          synchronous, active-high reset
//   i_rx         in   1          async serial line, idle high
//   o_data       out  DATA_BITS  received byte, stable while o_valid=1
//   o_valid      out  1          byte available; held until accepted
//   i_ready      in   1          consumer accepts o_data when o_valid&i_ready
//   o_busy       out  1          high in any state other than IDLE
//   o_frame_err  out  1          1-cycle pulse: stop bit sampled low
//   o_overrun    out  1          1-cycle pulse: frame completed while o_valid still high
// BEHAVIOUR
//   Reset (one clock with i_reset=1): state=IDLE; o_data=0, o_valid=0, o_busy=0,
//     o_frame_err=0, o_overrun=0; sync flops and edge-detect flop =1; counters=0.
//   Reset mid-frame aborts the frame; no output is produced for it.
//   Input: 2-flop synchronizer on i_rx -> rx_s; rx_d = rx_s delayed one cycle.
//   Tick: div counter 0..CLK_DIV-1, tick when ==CLK_DIV-1; counter cleared on IDLE exit.
//   FSM (tick counter tk 0..OVERSAMPLE-1, bit counter bc 0..DATA_BITS-1):
//     IDLE : on falling edge (rx_d=1 & rx_s=0) -> START, tk=0, bc=0.
//            Level-low without an edge (e.g. break after frame error) does not start a frame.
//     START: after OVERSAMPLE/2 ticks sample rx_s; 1 -> IDLE (glitch rejected, no flags);
//            0 -> DATA, tk=0.
//     DATA : every OVERSAMPLE ticks sample rx_s into shifter MSB, shift right (LSB first).
//            After bit DATA_BITS-1 -> STOP, tk=0.
//     STOP : after OVERSAMPLE ticks sample rx_s -> IDLE, then:
//            1 and o_valid=0 -> o_data<=shifter, o_valid<=1 next cycle;
//            1 and o_valid=1 -> o_overrun pulse, new byte dropped, old o_data kept;
//            0 -> o_frame_err pulse, byte discarded, o_valid/o_data unchanged.
//   Handshake: o_valid clears the cycle after o_valid&i_ready.
//     A byte completing in the same cycle as an accept is loaded (no overrun).
//   Latency: o_valid rises ~(1.5 + DATA_BITS) bit times + 3 clocks after the i_rx falling edge.
//     The stop sample is taken mid-stop-bit, so back-to-back frames are received.
//   Only the sample points within each bit are used; no majority vote.
// TESTING (CLK_DIV=4, OVERSAMPLE=16, DATA_BITS=8 -> 64 clk/bit)
//   1 Reset: i_reset=1 for 3 clk, i_rx=1 -> all outputs 0, o_busy=0.
//   2 Frame 0xA5 with valid stop, i_ready=1 -> o_data=0xA5, o_valid high exactly 1 clk,
//     at 608+-4 clk after start edge; no error flags.
//   3 Glitch: i_rx low 8 clk then high -> no o_valid, no flags; o_busy=0 within 40 clk.
//   4 Frame 0x3C with stop bit=0, line held low 200 clk, then high -> o_frame_err 1 pulse,
//     no o_valid, no restart while low. Next frame 0x55 -> o_data=0x55 valid.
//   5 i_ready=0; send 0x11 then 0x22 back-to-back -> o_valid held, o_data=0x11,
//     o_overrun 1 pulse at end of 0x22. Then i_ready=1 -> o_valid drops next clk.
//   6 i_reset pulse during data bit 3 of a frame -> o_busy=0 next clk, no output or flags.
//     Next frame 0x81 -> o_data=0x81.

Source files
------------

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: oversampled start detect, mid-bit sampling, LSB-first shift,
// valid/ready byte delivery with framing-error and overrun pulses.
module uart_rx_deser #(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TK_W  = $clog2(OVERSAMPLE);
  localparam int BC_W  = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TK_W-1:0]  TK_HALF  = TK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TK_W-1:0]  TK_LAST  = TK_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, rx_s_q, rx_d_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [TK_W-1:0]      tk_q, tk_d;
  logic [BC_W-1:0]      bc_q, bc_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick, stop_ok, stop_bad;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    tk_d     = tk_q;
    bc_d     = bc_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (state_q != IDLE) div_d = tick ? '0 : div_q + 1'b1;
    case (state_q)
      IDLE: begin
        div_d = '0;
        // Edge, not level: a line stuck low after a framing error must not restart.
        if (rx_d_q && !rx_s_q) begin
          state_d = START;
          tk_d    = '0;
          bc_d    = '0;
        end
      end
      START: if (tick) begin
        if (tk_q == TK_HALF) begin
          tk_d    = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else tk_d = tk_q + 1'b1;
      end
      DATA: if (tick) begin
        if (tk_q == TK_LAST) begin
          tk_d    = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bc_q == BC_LAST) state_d = STOP;
          else bc_d = bc_q + 1'b1;
        end else tk_d = tk_q + 1'b1;
      end
      STOP: if (tick) begin
        if (tk_q == TK_LAST) begin
          tk_d     = '0;
          state_d  = IDLE;
          stop_ok  = rx_s_q;
          stop_bad = !rx_s_q;
        end else tk_d = tk_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A byte finishing in the same cycle the consumer accepts is loaded, not dropped.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = stop_bad;
    ovr_d   = 1'b0;
    if (valid_q && i_ready) valid_d = 1'b0;
    if (stop_ok) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else ovr_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
      div_q   <= '0;
      tk_q    <= '0;
      bc_q    <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= i_rx;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
      div_q   <= div_d;
      tk_q    <= tk_d;
      bc_q    <= bc_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = (state_q != IDLE);
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: frames in, scoreboard of per-frame outcomes, per-cycle compare.
module tb_uart_rx_deser;
  localparam int BIT_CLK = 64;
  localparam int LAT_MIN = 604;
  localparam int LAT_MAX = 612;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_rx = 1'b1;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_busy, o_frame_err, o_overrun;

  uart_rx_deser #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_rx(i_rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_busy(o_busy), .o_frame_err(o_frame_err), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, nerr = 0;
  int n_load = 0, n_ferr = 0, n_ovr = 0, vcyc = 0;
  logic [7:0] last_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    nchk++;
    if (act < lo || act > hi) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Every tracked frame yields exactly one outcome: a delivered byte, an overrun or a framing error.
  typedef struct { logic [7:0] d; bit stp; int t0; } frame_t;
  frame_t q[$];

  bit         model_hold = 1'b0, prev_acc = 1'b0, prev_rst = 1'b0;
  logic [7:0] held_data = '0;

  always @(negedge clk) begin
    frame_t f;
    if (prev_rst) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ferr", o_frame_err, 0);
      chk("rst_ovr", o_overrun, 0);
      model_hold = 1'b0;
      prev_acc   = 1'b0;
    end else begin
      if (prev_acc) model_hold = 1'b0;
      if (o_frame_err) begin
        n_ferr++;
        if (q.size() == 0) chk("ferr_unexpected", 1, 0);
        else begin
          f = q.pop_front();
          chk("ferr_stopbit", f.stp, 0);
          chk_rng("ferr_latency", cyc - f.t0, LAT_MIN, LAT_MAX);
        end
      end
      if (o_overrun) begin
        n_ovr++;
        if (q.size() == 0) chk("ovr_unexpected", 1, 0);
        else begin
          f = q.pop_front();
          chk("ovr_stopbit", f.stp, 1);
          chk("ovr_holding", model_hold, 1);
          chk_rng("ovr_latency", cyc - f.t0, LAT_MIN, LAT_MAX);
        end
      end
      if (o_valid && !model_hold) begin
        n_load++;
        if (q.size() == 0) chk("load_unexpected", 1, 0);
        else begin
          f = q.pop_front();
          chk("load_stopbit", f.stp, 1);
          chk("load_data", o_data, f.d);
          chk_rng("load_latency", cyc - f.t0, LAT_MIN, LAT_MAX);
        end
        model_hold = 1'b1;
        held_data  = o_data;
        last_data  = o_data;
      end else if (model_hold) begin
        chk("data_stable", o_data, held_data);
      end
      chk("valid", o_valid, model_hold);
      if (o_valid) vcyc++;
      prev_acc = o_valid && i_ready;
    end
    prev_rst = i_reset;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // rst_at: clock offset within the frame at which a one-cycle reset is applied (-1 = none).
  task automatic send_frame(input logic [7:0] d, input bit stp, input bit track, input int rst_at);
    logic [9:0] fb;
    frame_t f;
    fb = {stp, d, 1'b0};
    if (track) begin
      f.d = d; f.stp = stp; f.t0 = cyc;
      q.push_back(f);
    end
    for (int i = 0; i < 10; i++) begin
      i_rx = fb[i];
      for (int j = 0; j < BIT_CLK; j++) begin
        i_reset = (rst_at == i * BIT_CLK + j);
        tick(1);
      end
    end
    i_reset = 1'b0;
    i_rx    = 1'b1;
  endtask

  initial begin
    // 1: reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_data", o_data, 0);
    chk("t1_valid", o_valid, 0);
    chk("t1_busy", o_busy, 0);
    chk("t1_ferr", o_frame_err, 0);
    chk("t1_ovr", o_overrun, 0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    tick(10);

    // 2: clean frame, consumer always ready
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    tick(32);
    chk("t2_data", last_data, 8'hA5);
    chk("t2_loads", n_load, 1);
    chk("t2_valid_cycles", vcyc, 1);
    chk("t2_flags", n_ferr + n_ovr, 0);

    // 3: short glitch is rejected at the start-bit midpoint
    i_rx = 1'b0;
    tick(8);
    i_rx = 1'b1;
    tick(12);
    @(negedge clk);
    chk("t3_busy_mid", o_busy, 1);
    @(posedge clk); #1;
    tick(19);
    @(negedge clk);
    chk("t3_busy_idle", o_busy, 0);
    @(posedge clk); #1;
    tick(640);
    chk("t3_loads", n_load, 1);
    chk("t3_flags", n_ferr + n_ovr, 0);

    // 4: bad stop bit, line held low, then a good frame
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    i_rx = 1'b0;
    tick(200);
    @(negedge clk);
    chk("t4_no_restart", o_busy, 0);
    @(posedge clk); #1;
    i_rx = 1'b1;
    tick(64);
    chk("t4_ferr", n_ferr, 1);
    chk("t4_loads", n_load, 1);
    send_frame(8'h55, 1'b1, 1'b1, -1);
    tick(32);
    chk("t4_data", last_data, 8'h55);
    chk("t4_loads2", n_load, 2);

    // 5: consumer stalled across two back-to-back frames
    i_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, -1);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    tick(32);
    @(negedge clk);
    chk("t5_valid_held", o_valid, 1);
    chk("t5_data_kept", o_data, 8'h11);
    chk("t5_ovr", n_ovr, 1);
    @(posedge clk); #1;
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_valid_drop", o_valid, 0);
    @(posedge clk); #1;
    tick(32);

    // 6: reset in the middle of data bit 3 aborts the frame
    send_frame(8'hFF, 1'b1, 1'b0, 4 * BIT_CLK + 32);
    tick(64);
    chk("t6_no_output", n_load, 3);
    send_frame(8'h81, 1'b1, 1'b1, -1);
    tick(32);
    chk("t6_data", last_data, 8'h81);
    chk("t6_loads", n_load, 4);

    tick(100);
    chk("end_queue_empty", q.size(), 0);
    chk("end_ferr", n_ferr, 1);
    chk("end_ovr", n_ovr, 1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
